// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: write-select encodings,
// forward-select values and the operand match modes used by fwd_match.
package fwd_scoreboard_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        WSEL_NONE     = 2'b00,
        WSEL_SCALAR   = 2'b01,
        WSEL_MAT_ELEM = 2'b10,
        WSEL_MAT_ALL  = 2'b11
    } wsel_e;

    // Forward-select value that means "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    typedef enum logic [1:0] {
        MATCH_SCALAR  = 2'b00,
        MATCH_MAT_SRC = 2'b01,
        MATCH_MAT_ANY = 2'b10
    } match_mode_e;

    function automatic logic is_mat_write(input wsel_e w);
        return (w == WSEL_MAT_ELEM) || (w == WSEL_MAT_ALL);
    endfunction

    function automatic logic writes_scalar(input wsel_e w, input logic [REG_W-1:0] rd);
        return (w == WSEL_SCALAR) && (rd != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one operand: finds the youngest bypass stage whose
// write satisfies the match mode and returns its 1-based index, else REGFILE.
module fwd_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_BYPASS = 2,
    parameter int SEL_W      = $clog2(NUM_BYPASS + 1)
) (
    input  logic [REG_W*NUM_BYPASS-1:0] stg_rd,
    input  logic [2*NUM_BYPASS-1:0]     stg_wsel,
    input  logic [REG_W-1:0]            src_reg,
    input  match_mode_e                 mode,
    output logic [SEL_W-1:0]            sel
);

    logic [NUM_BYPASS-1:0] hit;

    for (genvar k = 0; k < NUM_BYPASS; k++) begin : g_stage
        wsel_e            w;
        logic [REG_W-1:0] rd;
        logic             stage_hit;

        assign w  = wsel_e'(stg_wsel[2*k +: 2]);
        assign rd = stg_rd[REG_W*k +: REG_W];

        // A whole-matrix write covers every matrix element, so it matches any matrix source.
        always_comb begin
            stage_hit = 1'b0;
            case (mode)
                MATCH_SCALAR:  stage_hit = writes_scalar(w, rd) && (rd == src_reg);
                MATCH_MAT_SRC: stage_hit = ((w == WSEL_MAT_ELEM) && (rd == src_reg)) ||
                                           (w == WSEL_MAT_ALL);
                MATCH_MAT_ANY: stage_hit = is_mat_write(w);
                default:       stage_hit = 1'b0;
            endcase
        end

        assign hit[k] = stage_hit;
    end

    // Scan from the oldest stage so the youngest hit is the last one written.
    always_comb begin
        sel = SEL_W'(FWD_REGFILE);
        for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Latency scoreboard with bypass-select generation: tracks pending results per
// scalar register plus one matrix counter, stalls ID on RAW hazards, picks forwards.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter  int NUM_BYPASS = 2,
    parameter  int MAX_LAT    = 7,
    localparam int LAT_W      = $clog2(MAX_LAT + 1),
    localparam int SEL_W      = $clog2(NUM_BYPASS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [REG_W-1:0]            issue_rd,
    input  logic [1:0]                  issue_wsel,
    input  logic [LAT_W-1:0]            issue_lat,
    input  logic [REG_W-1:0]            id_rs1,
    input  logic [REG_W-1:0]            id_rs2,
    input  logic                        id_rs2_rsel,
    input  logic [REG_W-1:0]            ex_rs1,
    input  logic [REG_W-1:0]            ex_rs2,
    input  logic                        ex_rs2_rsel,
    input  logic [REG_W*NUM_BYPASS-1:0] stg_rd,
    input  logic [2*NUM_BYPASS-1:0]     stg_wsel,
    input  logic                        flush,
    output logic                        stall,
    output logic [SEL_W-1:0]            fwd_a,
    output logic [SEL_W-1:0]            fwd_b,
    output logic [SEL_W-1:0]            fwd_m,
    output logic [31:0]                 stall_cnt
);

    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] reg_cnt [NUM_REGS];
    logic [LAT_W-1:0] mat_cnt;
    logic [LAT_W-1:0] lat_load;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             do_issue;
    wsel_e            wsel;

    assign wsel = wsel_e'(issue_wsel);

    // A counter of 1 means the result reaches stage 1 next cycle and can be bypassed.
    always_comb begin
        rs1_busy = reg_cnt[id_rs1] > LAT_ONE;
        rs2_busy = id_rs2_rsel ? (reg_cnt[id_rs2] > LAT_ONE) : (mat_cnt > LAT_ONE);
        stall    = issue_valid && !flush && (rs1_busy || rs2_busy);
        do_issue = issue_valid && !stall && !flush;
        lat_load = (int'(issue_lat) > MAX_LAT) ? LAT_MAX : issue_lat;
    end

    // Entry 0 stays zero so x0 never looks busy; a fresh issue overrides the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_cnt[i] <= '0;
            end
            mat_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            reg_cnt[0] <= '0;
            if (flush) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    reg_cnt[i] <= '0;
                end
                mat_cnt <= '0;
            end else begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (do_issue && (wsel == WSEL_SCALAR) && (issue_rd == REG_W'(i))) begin
                        reg_cnt[i] <= lat_load;
                    end else if (reg_cnt[i] != '0) begin
                        reg_cnt[i] <= reg_cnt[i] - LAT_ONE;
                    end
                end
                if (do_issue && is_mat_write(wsel)) begin
                    mat_cnt <= lat_load;
                end else if (mat_cnt != '0) begin
                    mat_cnt <= mat_cnt - LAT_ONE;
                end
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    fwd_match #(
        .NUM_BYPASS (NUM_BYPASS),
        .SEL_W      (SEL_W)
    ) u_match_a (
        .stg_rd   (stg_rd),
        .stg_wsel (stg_wsel),
        .src_reg  (ex_rs1),
        .mode     (MATCH_SCALAR),
        .sel      (fwd_a)
    );

    fwd_match #(
        .NUM_BYPASS (NUM_BYPASS),
        .SEL_W      (SEL_W)
    ) u_match_b (
        .stg_rd   (stg_rd),
        .stg_wsel (stg_wsel),
        .src_reg  (ex_rs2),
        .mode     (ex_rs2_rsel ? MATCH_SCALAR : MATCH_MAT_SRC),
        .sel      (fwd_b)
    );

    fwd_match #(
        .NUM_BYPASS (NUM_BYPASS),
        .SEL_W      (SEL_W)
    ) u_match_m (
        .stg_rd   (stg_rd),
        .stg_wsel (stg_wsel),
        .src_reg  (ex_rs2),
        .mode     (MATCH_MAT_ANY),
        .sel      (fwd_m)
    );

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: a behavioural counter model predicts
// stall each cycle into a queue that is popped against the DUT.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_wsel;
    logic [2:0]  issue_lat;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs2_rsel;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_rs2_rsel;
    logic [9:0]  stg_rd;
    logic [3:0]  stg_wsel;
    logic        flush;

    logic        stall,   stall_c;
    logic [1:0]  fwd_a,   fwd_a_c;
    logic [1:0]  fwd_b,   fwd_b_c;
    logic [1:0]  fwd_m,   fwd_m_c;
    logic [31:0] stall_cnt, stall_cnt_c;

    int          total = 0;
    int          bad   = 0;

    int          m_cnt [32];
    int          m_mat;
    logic [31:0] m_scnt;
    logic        q_stall [$];
    logic        pend;
    logic        exp_s;

    typedef struct {
        logic [4:0] rd1;
        logic [1:0] w1;
        logic [4:0] rd2;
        logic [1:0] w2;
        logic [4:0] e1;
        logic [4:0] e2;
        logic       rsel;
        logic [1:0] ea;
        logic [1:0] eb;
        logic [1:0] em;
    } fwd_case_t;

    fwd_case_t cases [9];

    always #5 clk = ~clk;

    fwd_scoreboard #(.NUM_BYPASS(2), .MAX_LAT(7)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_wsel(issue_wsel), .issue_lat(issue_lat), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs2_rsel(id_rs2_rsel), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs2_rsel(ex_rs2_rsel),
        .stg_rd(stg_rd), .stg_wsel(stg_wsel), .flush(flush), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m), .stall_cnt(stall_cnt)
    );

    // Second instance with a smaller latency ceiling so the clamp is observable.
    fwd_scoreboard #(.NUM_BYPASS(2), .MAX_LAT(5)) dut_c (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_wsel(issue_wsel), .issue_lat(issue_lat), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs2_rsel(id_rs2_rsel), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs2_rsel(ex_rs2_rsel),
        .stg_rd(stg_rd), .stg_wsel(stg_wsel), .flush(flush), .stall(stall_c),
        .fwd_a(fwd_a_c), .fwd_b(fwd_b_c), .fwd_m(fwd_m_c), .stall_cnt(stall_cnt_c)
    );

    function automatic logic model_stall();
        logic b1;
        logic b2;
        b1 = m_cnt[id_rs1] > 1;
        b2 = id_rs2_rsel ? (m_cnt[id_rs2] > 1) : (m_mat > 1);
        return issue_valid && !flush && (b1 || b2);
    endfunction

    task automatic predict();
        pend = model_stall();
        q_stall.push_back(pend);
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic tick();
        int lat;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_mat  = 0;
            m_scnt = 32'd0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_mat = 0;
        end else begin
            for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) m_cnt[i]--;
            if (m_mat > 0) m_mat--;
            if (pend && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (issue_valid && !pend) begin
                lat = int'(issue_lat);
                if (lat > 7) lat = 7;
                if (issue_wsel == 2'b01 && issue_rd != 5'd0) m_cnt[issue_rd] = lat;
                if (issue_wsel == 2'b10 || issue_wsel == 2'b11) m_mat = lat;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_wsel = 2'b00; issue_lat = 3'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs2_rsel = 1'b1; flush = 1'b0;
    endtask

    task automatic settle();
        idle();
        for (int i = 0; i < 8; i++) begin
            pend = model_stall();
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ex_rs1 = 5'd5; ex_rs2 = 5'd0; ex_rs2_rsel = 1'b1;
        stg_rd = {5'd0, 5'd5}; stg_wsel = {2'b00, 2'b01};
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin issue_valid = 1'b1; id_rs1 = 5'd5; end
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL reset_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            tick();
        end
        #1;
        total++;
        if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        total++;
        if (fwd_a !== 2'd1) begin bad++; $display("[TB] FAIL reset_fwd_a got=%0d want=1", fwd_a); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_scalar_raw();
        int n;
        n = 0;
        stg_rd = '0; stg_wsel = '0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) begin issue_valid = 1'b1; issue_rd = 5'd5; issue_wsel = 2'b01; issue_lat = 3'd3; end
            if (i >= 2) begin issue_valid = 1'b1; id_rs1 = 5'd5; end
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL raw_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            if (stall === 1'b1) n++;
            tick();
        end
        total++;
        if (n != 1) begin bad++; $display("[TB] FAIL raw_stall_cycles got=%0d want=1", n); end
        stg_rd = {5'd0, 5'd5}; stg_wsel = {2'b00, 2'b01}; ex_rs1 = 5'd5;
        #1;
        total++;
        if (fwd_a !== 2'd1) begin bad++; $display("[TB] FAIL raw_fwd_a got=%0d want=1", fwd_a); end
        idle();
    endtask

    task automatic test_priority();
        cases[0] = '{5'd7, 2'b01, 5'd7, 2'b01, 5'd7, 5'd0, 1'b1, 2'd1, 2'd0, 2'd0};
        cases[1] = '{5'd0, 2'b01, 5'd0, 2'b01, 5'd0, 5'd0, 1'b1, 2'd0, 2'd0, 2'd0};
        cases[2] = '{5'd3, 2'b01, 5'd7, 2'b01, 5'd7, 5'd3, 1'b1, 2'd2, 2'd1, 2'd0};
        cases[3] = '{5'd4, 2'b10, 5'd6, 2'b01, 5'd6, 5'd4, 1'b0, 2'd2, 2'd1, 2'd1};
        cases[4] = '{5'd4, 2'b10, 5'd6, 2'b01, 5'd4, 5'd6, 1'b0, 2'd0, 2'd0, 2'd1};
        cases[5] = '{5'd4, 2'b10, 5'd6, 2'b01, 5'd4, 5'd6, 1'b1, 2'd0, 2'd2, 2'd1};
        cases[6] = '{5'd9, 2'b00, 5'd2, 2'b11, 5'd9, 5'd5, 1'b0, 2'd0, 2'd2, 2'd2};
        cases[7] = '{5'd1, 2'b11, 5'd1, 2'b01, 5'd1, 5'd1, 1'b1, 2'd2, 2'd2, 2'd1};
        cases[8] = '{5'd0, 2'b10, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 9; i++) begin
            stg_rd = {cases[i].rd2, cases[i].rd1};
            stg_wsel = {cases[i].w2, cases[i].w1};
            ex_rs1 = cases[i].e1; ex_rs2 = cases[i].e2; ex_rs2_rsel = cases[i].rsel;
            #1;
            total++;
            if (fwd_a !== cases[i].ea) begin bad++; $display("[TB] FAIL prio_fwd_a case=%0d got=%0d want=%0d", i, fwd_a, cases[i].ea); end
            total++;
            if (fwd_b !== cases[i].eb) begin bad++; $display("[TB] FAIL prio_fwd_b case=%0d got=%0d want=%0d", i, fwd_b, cases[i].eb); end
            total++;
            if (fwd_m !== cases[i].em) begin bad++; $display("[TB] FAIL prio_fwd_m case=%0d got=%0d want=%0d", i, fwd_m, cases[i].em); end
        end
        stg_rd = '0; stg_wsel = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rs2_rsel = 1'b1;
    endtask

    task automatic test_matrix();
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin issue_valid = 1'b1; issue_wsel = 2'b11; issue_lat = 3'd5; end
            if (i >= 2) begin issue_valid = 1'b1; id_rs2 = 5'd2; id_rs2_rsel = 1'b0; end
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL mat_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            if (stall === 1'b1) n++;
            tick();
        end
        total++;
        if (n != 3) begin bad++; $display("[TB] FAIL mat_stall_cycles got=%0d want=3", n); end
        stg_rd = {5'd0, 5'd0}; stg_wsel = {2'b11, 2'b00}; ex_rs2 = 5'd8; ex_rs2_rsel = 1'b0;
        #1;
        total++;
        if (fwd_b !== 2'd2) begin bad++; $display("[TB] FAIL mat_fwd_b got=%0d want=2", fwd_b); end
        total++;
        if (fwd_m !== 2'd2) begin bad++; $display("[TB] FAIL mat_fwd_m got=%0d want=2", fwd_m); end
        stg_rd = '0; stg_wsel = '0; ex_rs2 = '0; ex_rs2_rsel = 1'b1;
        idle();
    endtask

    task automatic test_flush();
        logic want;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) begin issue_valid = 1'b1; issue_rd = 5'd9; issue_wsel = 2'b01; issue_lat = 3'd7; end
            if (i >= 1) begin issue_valid = 1'b1; id_rs1 = 5'd9; end
            if (i == 2) flush = 1'b1;
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL flush_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            want = (i == 1);
            total++;
            if (stall !== want) begin bad++; $display("[TB] FAIL flush_stall_fixed cyc=%0d got=%b want=%b", i, stall, want); end
            tick();
        end
        idle();
    endtask

    task automatic test_same_cycle();
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 0) begin issue_valid = 1'b1; issue_rd = 5'd3; issue_wsel = 2'b01; issue_lat = 3'd3; end
            if (i == 2) begin issue_valid = 1'b1; issue_rd = 5'd3; issue_wsel = 2'b01; issue_lat = 3'd4; end
            if (i >= 3) begin issue_valid = 1'b1; id_rs1 = 5'd3; end
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL same_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            if (stall === 1'b1) n++;
            tick();
        end
        total++;
        if (n != 3) begin bad++; $display("[TB] FAIL same_stall_cycles got=%0d want=3", n); end
        idle();
    endtask

    task automatic test_clamp();
        int n;
        int nc;
        n = 0;
        nc = 0;
        settle();
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 0) begin issue_valid = 1'b1; issue_rd = 5'd6; issue_wsel = 2'b01; issue_lat = 3'd7; end
            else begin issue_valid = 1'b1; id_rs1 = 5'd6; end
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL clamp_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            if (stall === 1'b1) n++;
            if (stall_c === 1'b1) nc++;
            tick();
        end
        total++;
        if (n != 6) begin bad++; $display("[TB] FAIL clamp_max7_cycles got=%0d want=6", n); end
        total++;
        if (nc != 4) begin bad++; $display("[TB] FAIL clamp_max5_cycles got=%0d want=4", nc); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        idle();
        pend = model_stall();
        tick();
        rst = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd4; issue_wsel = 2'b01; issue_lat = 3'd7;
        id_rs1 = 5'd4; id_rs2_rsel = 1'b1;
        for (int i = 0; i < 60 && m_scnt != 32'd10; i++) begin
            predict();
            #1;
            exp_s = q_stall.pop_front();
            total++;
            if (stall !== exp_s) begin bad++; $display("[TB] FAIL mid_stall cyc=%0d got=%b want=%b", i, stall, exp_s); end
            tick();
        end
        total++;
        if (m_scnt != 32'd10) begin bad++; $display("[TB] FAIL mid_timeout model_cnt=%0d want=10", m_scnt); end
        #1;
        total++;
        if (stall_cnt !== 32'd10) begin bad++; $display("[TB] FAIL mid_stall_cnt got=%0d want=10", stall_cnt); end
        rst = 1'b1;
        predict();
        #1;
        exp_s = q_stall.pop_front();
        total++;
        if (stall !== exp_s) begin bad++; $display("[TB] FAIL mid_rst_stall got=%b want=%b", stall, exp_s); end
        tick();
        rst = 1'b0;
        predict();
        #1;
        exp_s = q_stall.pop_front();
        total++;
        if (stall !== 1'b0 || exp_s !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_stall got=%b want=0", stall); end
        total++;
        if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL post_rst_stall_cnt got=%0d want=0", stall_cnt); end
        tick();
        idle();
    endtask

    initial begin
        m_mat = 0;
        m_scnt = 32'd0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        rst = 1'b1;
        idle();
        ex_rs1 = '0; ex_rs2 = '0; ex_rs2_rsel = 1'b1;
        stg_rd = '0; stg_wsel = '0;

        test_reset();
        test_scalar_raw();
        test_priority();
        test_matrix();
        test_flush();
        test_same_cycle();
        test_clamp();
        #1;
        total++;
        if (stall_cnt !== m_scnt) begin bad++; $display("[TB] FAIL stall_cnt_track got=%0d want=%0d", stall_cnt, m_scnt); end
        test_reset_mid_stall();
        total++;
        if (q_stall.size() != 0) begin bad++; $display("[TB] FAIL queue_left got=%0d want=0", q_stall.size()); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
